// File: rtl/rics_pkg.sv
// Shared RICS datapath types and helpers used by the register file and its select decoding.
package rics_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned NREGS     = 1 << ADDR_W;
  // Widest select vector onehot_ok accepts; narrower vectors are zero-extended by callers.
  localparam int unsigned MAX_SEL_W = 256;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  function automatic logic onehot_ok(input logic [MAX_SEL_W-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_SEL_W; i++) begin
      if (vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/register_file_8x16_onehot_to_index.sv
// Converts a one-hot write select into a binary register index plus a validity flag.
module onehot_to_index
  import rics_pkg::*;
#(
  parameter int unsigned IDX_W = ADDR_W
) (
  input  logic [(1<<IDX_W)-1:0] sel,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  // idx is only meaningful when valid; OR-ing indices keeps the encoder cheap.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < (1 << IDX_W); i++) begin
      if (sel[i]) idx = idx | IDX_W'(i);
    end
    valid = onehot_ok(MAX_SEL_W'(sel));
  end

endmodule

// File: rtl/register_file_8x16.sv
// RICS general-purpose register file: one-hot write select, two registered read ports with bypass.
module register_file_8x16
  import rics_pkg::*;
#(
  parameter int unsigned DATA_W   = rics_pkg::DATA_W,
  parameter int unsigned ADDR_W   = rics_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [(1<<ADDR_W)-1:0]  wr_sel,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic [DATA_W-1:0]       rd_data_a,
  output logic [DATA_W-1:0]       rd_data_b,
  output logic                    sel_err,
  output logic [7:0]              wr_count
);

  localparam int unsigned NREGS_L = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS_L];
  logic [DATA_W-1:0] regs_d [NREGS_L];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              sel_err_q, sel_err_d;
  logic [7:0]        wr_count_q, wr_count_d;

  logic [ADDR_W-1:0] wr_idx;
  logic              sel_valid;
  logic              wr_ok;
  logic              zero_hit;

  onehot_to_index #(.IDX_W(ADDR_W)) u_sel (
    .sel   (wr_sel),
    .idx   (wr_idx),
    .valid (sel_valid)
  );

  // A write to R0 with ZERO_REG set still counts as accepted but stores nothing.
  always_comb begin
    wr_ok    = wr_en && sel_valid;
    zero_hit = ZERO_REG && (wr_idx == '0);
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS_L; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && !zero_hit && (wr_idx == ADDR_W'(i))) regs_d[i] = wr_data;
    end
  end

  // Bypass: a same-cycle valid write to the read address returns the new value.
  always_comb begin
    rd_data_a_d = regs_q[rd_addr_a];
    if (wr_ok && (rd_addr_a == wr_idx)) rd_data_a_d = zero_hit ? '0 : wr_data;
    rd_data_b_d = regs_q[rd_addr_b];
    if (wr_ok && (rd_addr_b == wr_idx)) rd_data_b_d = zero_hit ? '0 : wr_data;
  end

  always_comb begin
    sel_err_d  = wr_en && !sel_valid;
    wr_count_d = wr_count_q + 8'(wr_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS_L; i++) regs_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      sel_err_q   <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS_L; i++) regs_q[i] <= regs_d[i];
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      sel_err_q   <= sel_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign sel_err   = sel_err_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed self-checking bench for register_file_8x16 with ZERO_REG=1.
module tb_register_file_8x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_sel;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        sel_err;
  logic [7:0]  wr_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  register_file_8x16 #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .sel_err   (sel_err),
    .wr_count  (wr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] decode3(input logic [2:0] v);
    return 8'(1) << v;
  endfunction

  initial begin
    logic [7:0]  kb;
    logic [15:0] exp_a, exp_b;

    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    #12 rst_n = 1'b1;

    // Write R2 with same-cycle bypass on port A.
    tick();
    wr_en = 1'b1; wr_sel = 8'h04; wr_data = 16'h7777; rd_addr_a = 3'd2;
    tick();
    check("bypass_a_r2", 32'(rd_data_a), 32'h7777);
    check("cnt_after_first", 32'(wr_count), 32'd1);
    // Invalid select then asynchronous reset mid-cycle.
    wr_sel = 8'h03; wr_data = 16'hBEEF;
    tick();
    check("sel_err_pre_reset", 32'(sel_err), 32'd1);
    check("cnt_hold_invalid", 32'(wr_count), 32'd1);
    check("r2_kept", 32'(rd_data_a), 32'h7777);
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_a", 32'(rd_data_a), 32'h0);
    check("rst_rd_b", 32'(rd_data_b), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    check("rst_cnt", 32'(wr_count), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    check("r2_cleared", 32'(rd_data_a), 32'h0);

    // Write/read with one cycle of latency.
    wr_en = 1'b1; wr_sel = 8'h08; wr_data = 16'hA5A5; rd_addr_a = 3'd0;
    tick();
    check("cnt_1", 32'(wr_count), 32'd1);
    wr_en = 1'b0; rd_addr_a = 3'd3;
    tick();
    check("read_r3", 32'(rd_data_a), 32'hA5A5);
    check("cnt_still_1", 32'(wr_count), 32'd1);

    // Bypass on port B.
    wr_en = 1'b1; wr_sel = 8'h20; wr_data = 16'h1234; rd_addr_b = 3'd5;
    tick();
    check("bypass_b_r5", 32'(rd_data_b), 32'h1234);
    check("read_r3_again", 32'(rd_data_a), 32'hA5A5);
    check("cnt_2", 32'(wr_count), 32'd2);

    // Invalid selects leave R1/R2 and the counter untouched.
    wr_sel = 8'h02; wr_data = 16'h1111;
    tick();
    wr_sel = 8'h04; wr_data = 16'h2222;
    tick();
    check("cnt_4", 32'(wr_count), 32'd4);
    wr_sel = 8'h06; wr_data = 16'hDEAD; rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    tick();
    check("sel_err_06", 32'(sel_err), 32'd1);
    check("no_bypass_r1", 32'(rd_data_a), 32'h1111);
    check("no_bypass_r2", 32'(rd_data_b), 32'h2222);
    check("cnt_hold_06", 32'(wr_count), 32'd4);
    wr_sel = 8'h00; wr_data = 16'hDEAD;
    tick();
    check("sel_err_00", 32'(sel_err), 32'd1);
    check("cnt_hold_00", 32'(wr_count), 32'd4);
    wr_en = 1'b0; wr_sel = 8'h06;
    tick();
    check("sel_err_clear", 32'(sel_err), 32'd0);
    check("r1_intact", 32'(rd_data_a), 32'h1111);
    check("r2_intact", 32'(rd_data_b), 32'h2222);

    // Zero register: write accepted, value discarded, bypass returns 0.
    wr_en = 1'b1; wr_sel = 8'h01; wr_data = 16'hFFFF; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    tick();
    check("r0_bypass_a", 32'(rd_data_a), 32'h0);
    check("r0_bypass_b", 32'(rd_data_b), 32'h0);
    check("cnt_5", 32'(wr_count), 32'd5);
    wr_en = 1'b0;
    tick();
    check("r0_read_a", 32'(rd_data_a), 32'h0);
    check("r0_read_b", 32'(rd_data_b), 32'h0);

    // Counter wrap and decoder sweep from a clean reset.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      wr_en = 1'b1; wr_sel = decode3(kb[2:0]); wr_data = {kb, ~kb};
      tick();
      if (k == 254) check("cnt_255", 32'(wr_count), 32'd255);
    end
    check("cnt_wrap_0", 32'(wr_count), 32'd0);
    wr_en = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd_addr_a = 3'(r);
      rd_addr_b = 3'(7 - r);
      tick();
      kb = 8'(248 + r);
      exp_a = (r == 0) ? 16'h0 : {kb, ~kb};
      kb = 8'(248 + 7 - r);
      exp_b = (r == 7) ? 16'h0 : {kb, ~kb};
      check($sformatf("sweep_a_r%0d", r), 32'(rd_data_a), 32'(exp_a));
      check($sformatf("sweep_b_r%0d", 7 - r), 32'(rd_data_b), 32'(exp_b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
